// File: rtl/alu_md_seq_pkg.sv
// Shared decode constants and state encoding for the RV32M/RV64M multiply/divide unit.
// Holds the funct7/funct3 codes of the M extension, the aluop class they share with
// the ALU, the sequencer state enum and small operand-signedness helpers.
package alu_md_seq_pkg;

  localparam logic [2:0] ALUOP_MD      = 3'b000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic f3_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM.
  function automatic logic f3_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/alu_md_seq_divider.sv
// md_divider: restoring unsigned divide datapath, one quotient bit per step.
// Latency: XLEN step cycles after start; done is high during the final step.
// Ports: start loads dividend/divisor, step iterates, quot/rem hold the running
// quotient and partial remainder, done flags the last iteration.
module md_divider
  import alu_md_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem,
  output logic            done
);

  logic [XLEN-1:0]  dvs;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]    trial;
  logic [XLEN:0]    diff;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // remainder while quotient bits enter at the LSB. rem < dvs always holds, so
  // the top bit of diff is a clean borrow flag.
  always_comb begin
    trial = {rem, quot[XLEN-1]};
    diff  = trial - {1'b0, dvs};
  end

  assign done = step && (cnt == CNT_W'(XLEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot <= '0;
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
    end else if (start) begin
      quot <= dividend;
      rem  <= '0;
      dvs  <= divisor;
      cnt  <= '0;
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem  <= diff[XLEN-1:0];
        quot <= {quot[XLEN-2:0], 1'b1};
      end else begin
        rem  <= trial[XLEN-1:0];
        quot <= {quot[XLEN-2:0], 1'b0};
      end
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_md_seq.sv
// alu_md_seq: sequential M-extension multiply/divide unit beside the EX-stage ALU.
// Latency: XLEN+2 cycles from accept to out_valid (3 for multiplies with FAST_MUL_EN,
//   1 for divide-by-zero / signed overflow); result held in DONE until out_ready.
// Backpressure: in_ready only in IDLE; out_ready low holds result indefinitely; flush
//   returns to IDLE next edge and dominates accept/consume.
// Ports: in_valid/in_ready + aluop/funct3/funct7/op_a/op_b request; out_valid/out_ready
//   + result response; flush abort; busy = not IDLE; md_hit = fields decode to an M op.
// Build option: define FAST_MUL_EN for a single-cycle combinational multiply.
module alu_md_seq
  import alu_md_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      aluop,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            md_hit
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        f3_q;
  logic              neg_q;      // final value needs two's-complement negation
  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] acc;        // {partial product, remaining multiplier bits}
`ifndef FAST_MUL_EN
  logic [CNT_W-1:0]  cnt;
  logic [XLEN:0]     mul_sum;
`endif

  logic              accept;
  logic              sign_a;
  logic              sign_b;
  logic              is_div;
  logic              div_zero;
  logic              div_ovf;
  logic              div_start;
  logic              div_step;
  logic              div_done;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   special_res;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_fix;

  assign md_hit   = (aluop == ALUOP_MD) && (funct7 == FUNCT7_MULDIV);
  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid && in_ready && md_hit && !flush;

  // Operand decode at accept: sign extraction, magnitudes and the two divide
  // special cases that bypass iteration.
  always_comb begin
    sign_a   = f3_signed_a(funct3) && op_a[XLEN-1];
    sign_b   = f3_signed_b(funct3) && op_b[XLEN-1];
    mag_a    = sign_a ? -op_a : op_a;
    mag_b    = sign_b ? -op_b : op_b;
    is_div   = funct3[2];
    div_zero = (op_b == '0);
    // Only DIV (100) and REM (110) are signed, hence funct3[0] == 0.
    div_ovf  = !funct3[0] && (op_a == MOST_NEG) && (op_b == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = funct3[1] ? op_a : '1;
    end else if (div_ovf) begin
      special_res = funct3[1] ? '0 : op_a;
    end
  end

  assign div_start = accept && is_div && !div_zero && !div_ovf;
  assign div_step  = (state == S_DIV);

  md_divider #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_md_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quot     (quot),
    .rem      (rem),
    .done     (div_done)
  );

`ifndef FAST_MUL_EN
  // Shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator right, consuming one multiplier bit.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
`endif

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    div_fix  = f3_q[1] ? rem : quot;
    if (neg_q) begin
      div_fix = -div_fix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      mcand     <= '0;
      acc       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
`ifndef FAST_MUL_EN
      cnt       <= '0;
`endif
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            f3_q  <= funct3;
            mcand <= mag_a;
            acc   <= {{XLEN{1'b0}}, mag_b};
            // Remainder follows the dividend; products and quotients follow the xor.
            neg_q <= (is_div && funct3[1]) ? sign_a : (sign_a ^ sign_b);
`ifndef FAST_MUL_EN
            cnt   <= '0;
`endif
            if (is_div && (div_zero || div_ovf)) begin
              result    <= special_res;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else if (is_div) begin
              state <= S_DIV;
            end else begin
              state <= S_MUL;
            end
          end
        end
        S_MUL: begin
`ifdef FAST_MUL_EN
          acc   <= {{XLEN{1'b0}}, mcand} * {{XLEN{1'b0}}, acc[XLEN-1:0]};
          state <= S_FIX;
`else
          acc <= {mul_sum, acc[XLEN-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN - 1)) begin
            state <= S_FIX;
          end
`endif
        end
        S_DIV: begin
          if (div_done) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (f3_q[2]) begin
            result <= div_fix;
          end else if (f3_q == F3_MUL) begin
            result <= prod_fix[XLEN-1:0];
          end else begin
            result <= prod_fix[2*XLEN-1:XLEN];
          end
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_seq.sv
// Self-checking bench for alu_md_seq at XLEN=32: reset, multiply, divide, special
// cases, backpressure, non-M requests, flush and asynchronous reset mid-divide.
// Build option FAST_MUL_EN shortens the expected multiply latency to 3 cycles.
module tb_alu_md_seq;
  import alu_md_seq_pkg::*;

  localparam int XLEN = 32;
`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = XLEN + 2;
`endif
  localparam int DIV_LAT = XLEN + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  aluop;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
  logic        md_hit;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  alu_md_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .funct3    (funct3),
    .funct7    (funct7),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .md_hit    (md_hit)
  );

  // Reference model built on native 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q;
    logic [63:0]     p;
    sa = $signed(a);
    sb = $signed(b);
    case (f3)
      F3_MUL:    begin p = sa * sb; return p[31:0]; end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        q = sa / sb; p = q; return p[31:0];
      end
      F3_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = sa % sb; p = q; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return DIV_LAT;
  endfunction

  // Drives one M op, records its expectation, returns #1 after the accept edge.
  // Operands are scrambled afterwards so any re-sampling shows up as a wrong result.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; aluop = ALUOP_MD; funct7 = FUNCT7_MULDIV;
    funct3 = f3; op_a = a; op_b = b;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    @(posedge clk); #1;
    in_valid = 1'b0;
    funct3 = 3'($urandom());
    op_a = $urandom();
    op_b = $urandom();
  endtask

  // Latency counts the accept edge as cycle 1; -1 means out_valid never came.
  task automatic wait_out(output logic [31:0] r, output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
    r = result;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    aluop = 3'b0; funct3 = 3'b0; funct7 = 7'b0; op_a = '0; op_b = '0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [2:0]  tf [3] = '{F3_MUL, F3_MULH, F3_MULHU};
    logic [31:0] ta [3] = '{32'd7, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] tv [3] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] te [3] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE};
    for (int i = 0; i < 11; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b, x, got, e;
      int lg, el;
      if (i < 3) begin f = tf[i]; a = ta[i]; b = tv[i]; x = te[i]; end
      else begin f = 3'($urandom_range(0, 3)); a = $urandom(); b = $urandom(); x = ref_md(f, a, b); end
      issue(f, a, b, x, exp_lat(f, a, b));
      wait_out(got, lg);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL mul_result[%0d] f3=%0d a=%h b=%h: got %h expected %h", i, f, a, b, got, e); end
      checks++; if (lg !== el) begin errors++; $display("FAIL mul_latency[%0d]: got %0d expected %0d", i, lg, el); end
      consume();
    end
  endtask

  task automatic test_div();
    logic [2:0]  tf [4] = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU};
    logic [31:0] ta [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] tv [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] te [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b, x, got, e;
      int lg, el;
      if (i < 4) begin f = tf[i]; a = ta[i]; b = tv[i]; x = te[i]; end
      else begin
        f = 3'($urandom_range(4, 7)); a = $urandom();
        b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : ($urandom() | 32'h1);
        if (i % 3 == 0) b = -b;
        x = ref_md(f, a, b);
      end
      issue(f, a, b, x, exp_lat(f, a, b));
      wait_out(got, lg);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL div_result[%0d] f3=%0d a=%h b=%h: got %h expected %h", i, f, a, b, got, e); end
      checks++; if (lg !== el) begin errors++; $display("FAIL div_latency[%0d]: got %0d expected %0d", i, lg, el); end
      consume();
    end
  endtask

  task automatic test_special();
    logic [2:0]  tf [6] = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU, F3_DIV, F3_REM};
    logic [31:0] ta [6] = '{32'h1234, 32'h1234, 32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
    logic [31:0] tv [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] te [6] = '{32'hFFFFFFFF, 32'h1234, 32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};
    for (int i = 0; i < 6; i++) begin
      logic [31:0] got, e;
      int lg, el;
      issue(tf[i], ta[i], tv[i], te[i], 1);
      wait_out(got, lg);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL special_result[%0d]: got %h expected %h", i, got, e); end
      checks++; if (lg !== el) begin errors++; $display("FAIL special_latency[%0d]: got %0d expected %0d", i, lg, el); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got, e;
    int lg, el;
    out_ready = 1'b0;
    issue(F3_MUL, 32'd123, 32'd456, 32'd56088, MUL_LAT);
    wait_out(got, lg);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL bp_result: got %h expected %h", got, e); end
    checks++; if (lg !== el) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lg, el); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (result !== e) begin errors++; $display("FAIL bp_hold_result[%0d]: got %h expected %h", i, result, e); end
      checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL bp_hold_flags[%0d]: got valid=%b busy=%b expected 1/1", i, out_valid, busy); end
    end
    consume();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got valid=%b busy=%b ready=%b expected 0/0/1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_non_m();
    in_valid = 1'b1; aluop = 3'b000; funct7 = 7'b0100000; funct3 = F3_MUL; op_a = 32'd5; op_b = 32'd6;
    #1;
    checks++; if (md_hit !== 1'b0) begin errors++; $display("FAIL non_m_hit: got %b expected 0", md_hit); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL non_m_accept: got busy=%b ready=%b expected 0/1", busy, in_ready); end
    in_valid = 1'b0; aluop = 3'b010; funct7 = FUNCT7_MULDIV;
    #1;
    checks++; if (md_hit !== 1'b0) begin errors++; $display("FAIL non_m_aluop_hit: got %b expected 0", md_hit); end
    aluop = ALUOP_MD;
    #1;
    checks++; if (md_hit !== 1'b1) begin errors++; $display("FAIL m_hit: got %b expected 1", md_hit); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic [31:0] got, e, x;
    int lg, el, seen;
    // Flush during divide iteration 3.
    issue(F3_DIVU, 32'd1000, 32'd3, 32'd333, DIV_LAT);
    void'(exp_q.pop_front()); void'(lat_q.pop_front());
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_mid: got busy=%b ready=%b valid=%b expected 0/1/0", busy, in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_output: got %0d valid cycles expected 0", seen); end
    // Flush together with consume drops the result.
    out_ready = 1'b0;
    issue(F3_REMU, 32'd1000, 32'd0, 32'd1000, 1);
    wait_out(got, lg);
    void'(exp_q.pop_front()); void'(lat_q.pop_front());
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_consume: got valid=%b busy=%b expected 0/0", out_valid, busy); end
    // Flush dominates a simultaneous accept.
    in_valid = 1'b1; aluop = ALUOP_MD; funct7 = FUNCT7_MULDIV; funct3 = F3_MUL; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_accept: got busy=%b expected 0", busy); end
    // Unit is still healthy afterwards.
    x = ref_md(F3_MULHSU, 32'hFFFFFF00, 32'h80000001);
    issue(F3_MULHSU, 32'hFFFFFF00, 32'h80000001, x, MUL_LAT);
    wait_out(got, lg);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL post_flush_result: got %h expected %h", got, e); end
    checks++; if (lg !== el) begin errors++; $display("FAIL post_flush_latency: got %0d expected %0d", lg, el); end
    consume();
  endtask

  task automatic test_reset_mid_div();
    issue(F3_DIV, 32'h12345678, 32'd3, ref_md(F3_DIV, 32'h12345678, 32'd3), DIV_LAT);
    void'(exp_q.pop_front()); void'(lat_q.pop_front());
    repeat (9) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_flags: got valid=%b ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy);
    end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_mid_result: got %h expected 0", result); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_non_m();
    test_flush();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
